// File: rtl/sgm_bcd_rx_pkg.sv
// Shared segment-pattern constants and FSM state type for the segment readback path.
// The BCD-to-segment encoder uses the same constants, so encoder and decoder cannot drift apart.
package sgm_bcd_rx_pkg;

    // Active-high segment patterns, bit0 = a ... bit6 = g
    localparam logic [6:0] SGM_0     = 7'h3F;
    localparam logic [6:0] SGM_1     = 7'h06;
    localparam logic [6:0] SGM_2     = 7'h5B;
    localparam logic [6:0] SGM_3     = 7'h4F;
    localparam logic [6:0] SGM_4     = 7'h66;
    localparam logic [6:0] SGM_5     = 7'h6D;
    localparam logic [6:0] SGM_6     = 7'h7D;
    localparam logic [6:0] SGM_7     = 7'h07;
    localparam logic [6:0] SGM_8     = 7'h7F;
    localparam logic [6:0] SGM_9     = 7'h6F;
    localparam logic [6:0] SGM_BLANK = 7'h00;

    localparam logic [3:0] BCD_BAD   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sgm_bcd.sv
// Combinational 7-segment to BCD decoder, the exact inverse of bcd_sgm.
// Unknown patterns (blank included) decode to BCD_BAD with valid low.
module sgm_bcd
    import sgm_bcd_rx_pkg::*;
(
    input  logic [6:0] sgm,
    output logic       valid,
    output logic [3:0] bcd
);

    always_comb begin
        valid = 1'b1;
        bcd   = 4'h0;
        case (sgm)
            SGM_0:   bcd = 4'd0;
            SGM_1:   bcd = 4'd1;
            SGM_2:   bcd = 4'd2;
            SGM_3:   bcd = 4'd3;
            SGM_4:   bcd = 4'd4;
            SGM_5:   bcd = 4'd5;
            SGM_6:   bcd = 4'd6;
            SGM_7:   bcd = 4'd7;
            SGM_8:   bcd = 4'd8;
            SGM_9:   bcd = 4'd9;
            default: begin
                valid = 1'b0;
                bcd   = BCD_BAD;
            end
        endcase
    end

endmodule

// File: rtl/sgm_bcd_rx.sv
// Segment-stream receiver: decodes strobed 7-segment patterns, assembles N_DIG digits
// into a frame and offers it on a valid/ready output with an invalid-pattern flag.
module sgm_bcd_rx
    import sgm_bcd_rx_pkg::*;
#(
    parameter int N_DIG       = 4,
    parameter bit SGM_ACT_LOW = 1'b0
)(
    input  logic                 ck,
    input  logic                 rst_s,
    input  logic [6:0]           sgm,
    input  logic                 stb,
    input  logic                 frm,
    input  logic                 out_rdy,
    output logic                 out_vld,
    output logic [4*N_DIG-1:0]   bcd_val,
    output logic                 err,
    output logic                 ovr
);

    localparam int W  = 4 * N_DIG;
    localparam int CW = $clog2(N_DIG + 1);

    logic [6:0]     sgm_hi;
    logic           dig_ok;
    logic [3:0]     dig;
    rx_state_t      state;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   shreg;
    logic [W-1:0]   shreg_nxt;
    logic           err_acc;
    logic           begin_frame;

    assign sgm_hi = SGM_ACT_LOW ? ~sgm : sgm;

    sgm_bcd u_dec (
        .sgm   (sgm_hi),
        .valid (dig_ok),
        .bcd   (dig)
    );

    assign shreg_nxt = (shreg << 4) | W'(dig);

    // A start marker opens a new frame anywhere except in HOLD, where it needs the handshake too
    assign begin_frame = stb && frm && ((state != ST_HOLD) || out_rdy);

    always_ff @(posedge ck) begin
        if (rst_s) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            shreg   <= '0;
            err_acc <= 1'b0;
            bcd_val <= '0;
            out_vld <= 1'b0;
            err     <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            ovr <= 1'b0;
            case (state)
                ST_IDLE: ;
                ST_COLLECT: begin
                    if (stb && !frm) begin
                        if (cnt == CW'(N_DIG - 1)) begin
                            bcd_val <= shreg_nxt;
                            err     <= err_acc | ~dig_ok;
                            out_vld <= 1'b1;
                            cnt     <= '0;
                            state   <= ST_HOLD;
                        end else begin
                            shreg   <= shreg_nxt;
                            err_acc <= err_acc | ~dig_ok;
                            cnt     <= cnt + CW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_rdy) begin
                        out_vld <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (stb) begin
                        ovr <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Placed last so a frame start overrides the per-state updates above
            if (begin_frame) begin
                shreg   <= W'(dig);
                cnt     <= CW'(1);
                err_acc <= ~dig_ok;
                if (N_DIG == 1) begin
                    bcd_val <= W'(dig);
                    err     <= ~dig_ok;
                    out_vld <= 1'b1;
                    state   <= ST_HOLD;
                end else begin
                    state   <= ST_COLLECT;
                end
            end
        end
    end

endmodule

// File: tb/tb_sgm_bcd_rx.sv
// Scoreboard bench for sgm_bcd_rx: a 4-digit active-high instance and a 1-digit active-low
// instance share one stimulus stream and are checked against a frame-level reference model.
module tb_sgm_bcd_rx;

    logic        ck = 1'b0;
    logic        rst_s = 1'b1;
    logic        stb = 1'b0;
    logic        frm = 1'b0;
    logic        out_rdy = 1'b0;
    logic [6:0]  sgm = 7'h00;
    logic [6:0]  sgm_inv;

    logic        vld0, err0, ovr0;
    logic [15:0] bcd0;
    logic        vld1, err1, ovr1;
    logic [3:0]  bcd1;

    always #5 ck = ~ck;

    assign sgm_inv = ~sgm;

    sgm_bcd_rx #(.N_DIG(4), .SGM_ACT_LOW(1'b0)) dut0 (
        .ck(ck), .rst_s(rst_s), .sgm(sgm), .stb(stb), .frm(frm), .out_rdy(out_rdy),
        .out_vld(vld0), .bcd_val(bcd0), .err(err0), .ovr(ovr0)
    );

    sgm_bcd_rx #(.N_DIG(1), .SGM_ACT_LOW(1'b1)) dut1 (
        .ck(ck), .rst_s(rst_s), .sgm(sgm_inv), .stb(stb), .frm(frm), .out_rdy(out_rdy),
        .out_vld(vld1), .bcd_val(bcd1), .err(err1), .ovr(ovr1)
    );

    typedef struct packed {
        logic [31:0] bcd;
        logic        err;
    } frame_t;

    frame_t      sbq0[$];
    frame_t      sbq1[$];

    logic [6:0]  segTab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int          nDig [2] = '{4, 1};

    logic [31:0] mAcc [2];
    int          mCnt [2];
    bit          mErr [2];
    bit          mInFrame [2];
    bit          mHold [2];
    bit          mRst [2];
    bit          expVld [2];
    bit          expOvr [2];
    bit          expErr [2];
    logic [31:0] expBcd [2];
    bit          prevVld [2];
    bit          prevHs [2];
    bit          started = 1'b0;

    int          nChecks = 0;
    int          nPass = 0;

    function automatic int decodeRef(input logic [6:0] p);
        for (int k = 0; k < 10; k++)
            if (segTab[k] == p) return k;
        return 15;
    endfunction

    // Frame-level reference: a frame is a running base-16 number plus a digit count
    task automatic modelStep(input int i);
        int d;
        bit beginF;
        frame_t f;
        d = decodeRef(sgm);
        expOvr[i] = 1'b0;
        mRst[i] = rst_s;
        if (rst_s) begin
            mInFrame[i] = 1'b0;
            mHold[i] = 1'b0;
            mCnt[i] = 0;
            expVld[i] = 1'b0;
            expBcd[i] = 32'h0;
            expErr[i] = 1'b0;
            if (i == 0) sbq0.delete(); else sbq1.delete();
            return;
        end
        beginF = 1'b0;
        if (mHold[i]) begin
            if (out_rdy) begin
                mHold[i] = 1'b0;
                expVld[i] = 1'b0;
                beginF = stb && frm;
            end else if (stb) begin
                expOvr[i] = 1'b1;
            end
        end else if (stb && frm) begin
            beginF = 1'b1;
        end else if (stb && mInFrame[i]) begin
            mAcc[i] = mAcc[i] * 16 + 32'(d);
            mCnt[i]++;
            mErr[i] = mErr[i] || (d == 15);
        end
        if (beginF) begin
            mAcc[i] = 32'(d);
            mCnt[i] = 1;
            mErr[i] = (d == 15);
            mInFrame[i] = 1'b1;
        end
        if (mInFrame[i] && mCnt[i] == nDig[i]) begin
            mInFrame[i] = 1'b0;
            mHold[i] = 1'b1;
            expVld[i] = 1'b1;
            expBcd[i] = mAcc[i];
            expErr[i] = mErr[i];
            f.bcd = mAcc[i];
            f.err = mErr[i];
            if (i == 0) sbq0.push_back(f); else sbq1.push_back(f);
        end
    endtask

    always @(posedge ck) begin
        if (rst_s) started = 1'b1;
        modelStep(0);
        modelStep(1);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle output checks, plus a scoreboard pop whenever a new frame is first presented
    task automatic monitorInst(input int i, input logic vld, input logic er, input logic ov,
                               input logic [31:0] bcd, input logic rdy);
        frame_t f;
        checkOutput($sformatf("out_vld%0d", i), 32'(vld), 32'(expVld[i]));
        checkOutput($sformatf("ovr%0d", i), 32'(ov), 32'(expOvr[i]));
        checkOutput($sformatf("bcd_val%0d", i), bcd, expBcd[i]);
        if (vld === 1'b1 || mRst[i])
            checkOutput($sformatf("err%0d", i), 32'(er), 32'(expErr[i]));
        if (vld === 1'b1 && (!prevVld[i] || prevHs[i])) begin
            if ((i == 0 && sbq0.size() == 0) || (i == 1 && sbq1.size() == 0)) begin
                nChecks++;
                $display("[TB] FAIL sb_frame%0d: got frame %0h, expected no frame at %0t", i, bcd, $time);
            end else begin
                f = (i == 0) ? sbq0.pop_front() : sbq1.pop_front();
                checkOutput($sformatf("sb_bcd%0d", i), bcd, f.bcd);
                checkOutput($sformatf("sb_err%0d", i), 32'(er), 32'(f.err));
            end
        end
        prevVld[i] = (vld === 1'b1);
        prevHs[i] = (vld === 1'b1) && rdy;
    endtask

    always @(negedge ck) begin
        if (started) begin
            monitorInst(0, vld0, err0, ovr0, 32'(bcd0), out_rdy);
            monitorInst(1, vld1, err1, ovr1, 32'(bcd1), out_rdy);
        end
    end

    task automatic applyStimulus(input bit s, input bit f, input logic [6:0] p,
                                 input bit r, input bit rs);
        stb = s;
        frm = f;
        sgm = p;
        out_rdy = r;
        rst_s = rs;
        @(posedge ck);
        #1;
    endtask

    initial begin
        logic [6:0] p;
        applyStimulus(0, 0, 7'h00, 0, 1);
        applyStimulus(0, 0, 7'h00, 0, 1);

        // Nominal 1234 frame, held, then handshake
        applyStimulus(1, 1, 7'h06, 0, 0);
        applyStimulus(1, 0, 7'h5B, 0, 0);
        applyStimulus(1, 0, 7'h4F, 0, 0);
        applyStimulus(1, 0, 7'h66, 0, 0);
        applyStimulus(0, 0, 7'h00, 0, 0);
        applyStimulus(0, 0, 7'h00, 1, 0);
        applyStimulus(0, 0, 7'h00, 0, 0);

        // Blank digit flags the frame
        applyStimulus(1, 1, 7'h3F, 0, 0);
        applyStimulus(1, 0, 7'h00, 0, 0);
        applyStimulus(1, 0, 7'h7F, 0, 0);
        applyStimulus(1, 0, 7'h6F, 0, 0);
        applyStimulus(0, 0, 7'h00, 1, 0);
        applyStimulus(0, 0, 7'h00, 0, 0);

        // Idle strobe, then restart mid-frame
        applyStimulus(1, 0, 7'h3F, 0, 0);
        applyStimulus(1, 1, 7'h06, 0, 0);
        applyStimulus(1, 0, 7'h5B, 0, 0);
        applyStimulus(1, 1, 7'h6D, 0, 0);
        applyStimulus(1, 0, 7'h7D, 0, 0);
        applyStimulus(1, 0, 7'h07, 0, 0);
        applyStimulus(1, 0, 7'h3F, 0, 0);
        applyStimulus(0, 0, 7'h00, 0, 0);

        // Overrun while held, then handshake together with a new frame start
        applyStimulus(1, 0, 7'h06, 0, 0);
        applyStimulus(1, 1, 7'h4F, 1, 0);
        applyStimulus(1, 0, 7'h5B, 0, 0);
        applyStimulus(1, 0, 7'h4F, 0, 0);
        applyStimulus(1, 0, 7'h66, 0, 0);
        applyStimulus(0, 0, 7'h00, 1, 0);

        // Single-digit frame for the 1-digit instance
        applyStimulus(1, 1, 7'h07, 0, 0);
        applyStimulus(0, 0, 7'h00, 1, 0);

        // Reset mid-frame, then 9999
        applyStimulus(1, 1, 7'h06, 0, 0);
        applyStimulus(1, 0, 7'h5B, 0, 0);
        applyStimulus(0, 0, 7'h00, 0, 1);
        applyStimulus(1, 1, 7'h6F, 0, 0);
        applyStimulus(1, 0, 7'h6F, 0, 0);
        applyStimulus(1, 0, 7'h6F, 0, 0);
        applyStimulus(1, 0, 7'h6F, 0, 0);
        applyStimulus(0, 0, 7'h00, 1, 0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) != 0) p = segTab[$urandom_range(9)];
            else p = 7'($urandom);
            applyStimulus($urandom_range(9) < 6, $urandom_range(3) == 0, p,
                          $urandom_range(1) == 1, $urandom_range(99) == 0);
        end

        repeat (4) applyStimulus(0, 0, 7'h00, 1, 0);
        #5;
        checkOutput("sb_empty0", 32'(sbq0.size()), 32'h0);
        checkOutput("sb_empty1", 32'(sbq1.size()), 32'h0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
